// File: rtl/gpio_keypad_if.sv
// Keypad pins and decoded-key outputs for gpio_keypad; master is the scanner side.
interface gpio_keypad_if;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] gpio;

   modport master (
      output col,
      input  row,
      output key_code,
      output key_valid,
      output key_down,
      output gpio
   );

   modport slave (
      input  col,
      output row,
      input  key_code,
      input  key_valid,
      input  key_down,
      input  gpio
   );
endinterface

// File: rtl/gpio_keypad.sv
// 4x4 keypad scanner with frame-level debounce; accepted key appears one cycle after the
// deciding frame's column-3 sample, no backpressure (key_valid is a fire-and-forget pulse).
module gpio_keypad #(
   parameter int SCAN_PERIOD = 65536,
   parameter int DEBOUNCE    = 3
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   gpio_keypad_if.master   kp
);

   localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_PERIOD - 1);
   localparam logic [3:0]    DB        = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   logic [SW-1:0] slot;
   logic [1:0]    col_idx;
   logic [3:0]    col_q;
   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic          slot_last;
   logic          frame_evt;

   logic [1:0]    acc_cnt;
   logic [3:0]    acc_code;
   logic [1:0]    samp_r;
   logic [2:0]    n_low;
   logic [3:0]    tot;
   logic [3:0]    frame_code;
   logic          frame_vld;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [3:0]    cand, cand_n;
   logic          accept;
   logic          release_evt;
   logic          match;

   logic [3:0]    key_code_q;
   logic          key_valid_q;
   logic          key_down_q;
   logic [15:0]   gpio_q;

   function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   assign slot_last = (slot == SLOT_LAST);
   assign frame_evt = slot_last && (col_idx == 2'd3);

   // Column strobe is registered together with the index so the two never disagree.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slot    <= '0;
         col_idx <= 2'd0;
         col_q   <= 4'b1110;
      end else if (slot_last) begin
         slot    <= '0;
         col_idx <= col_idx + 2'd1;
         col_q   <= ~(4'b0001 << (col_idx + 2'd1));
      end else begin
         slot    <= slot + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         row_meta <= '0;
         row_sync <= '0;
      end else begin
         row_meta <= kp.row;
         row_sync <= row_meta;
      end
   end

   always_comb begin
      samp_r = 2'd0;
      n_low  = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!row_sync[i]) begin
            samp_r = 2'(i);
            n_low  = n_low + 3'd1;
         end
      end
   end

   // acc_cnt saturates at 2: anything beyond one pressed position is already "NONE".
   assign tot        = {2'b00, acc_cnt} + {1'b0, n_low};
   assign frame_code = (n_low == 3'd1) ? key_lut(samp_r, col_idx) : acc_code;
   assign frame_vld  = frame_evt && (tot == 4'd1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'h0;
      end else if (slot_last) begin
         if (col_idx == 2'd3) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
         end else begin
            acc_cnt  <= (tot >= 4'd2) ? 2'd2 : tot[1:0];
            acc_code <= frame_code;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         cnt   <= 4'd0;
         cand  <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   assign match = frame_vld && (frame_code == cand);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      accept      = 1'b0;
      release_evt = 1'b0;
      if (frame_evt) begin
         case (state)
            IDLE: begin
               if (frame_vld) begin
                  cand_n = frame_code;
                  cnt_n  = 4'd1;
                  if (DB == 4'd1) begin
                     accept  = 1'b1;
                     state_n = HELD;
                  end else begin
                     state_n = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (!frame_vld) begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end else if (match) begin
                  cnt_n = cnt + 4'd1;
                  if (cnt + 4'd1 == DB) begin
                     accept  = 1'b1;
                     state_n = HELD;
                  end
               end else begin
                  cand_n = frame_code;
                  cnt_n  = 4'd1;
               end
            end
            HELD: begin
               if (!match) begin
                  if (DB == 4'd1) begin
                     release_evt = 1'b1;
                     state_n     = IDLE;
                     cnt_n       = 4'd0;
                  end else begin
                     state_n = REL_DB;
                     cnt_n   = 4'd1;
                  end
               end
            end
            default: begin
               if (match) begin
                  state_n = HELD;
                  cnt_n   = 4'd0;
               end else if (cnt + 4'd1 == DB) begin
                  release_evt = 1'b1;
                  state_n     = IDLE;
                  cnt_n       = 4'd0;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         gpio_q      <= 16'h0000;
      end else begin
         key_valid_q <= accept;
         if (accept) begin
            key_code_q <= cand_n;
            gpio_q     <= {gpio_q[11:0], cand_n};
            key_down_q <= 1'b1;
         end else if (release_evt) begin
            key_down_q <= 1'b0;
         end
      end
   end

   assign kp.col       = col_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;
   assign kp.gpio      = gpio_q;

endmodule

// File: doc/gpio_keypad.md
GPIO_KEYPAD -- requirements
Module: gpio_keypad

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 65536: clk_i cycles per column slot, legal range 4..65536.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive identical scan frames required to accept a press or a release, legal range 1..15.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, all state rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port col, output, 4 bits: active-low column strobe to the 4x4 keypad, exactly one bit low outside reset.
REQ-006 SHALL have port row, input, 4 bits: active-low row sense (pulled up, asynchronous to clk_i).
REQ-007 SHALL have port key_code, output, 4 bits: hex code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted press.
REQ-009 SHALL have port key_down, output, 1 bit: high while a debounced key is held.
REQ-010 SHALL have port gpio, output, 16 bits: last four accepted codes, newest in [3:0], directly displayable by the seven-segment driver.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; only the synchronized value is used.
REQ-012 SHALL run slot counter 0..SCAN_PERIOD-1, wrapping; on wrap, column index advances 0->1->2->3->0.
REQ-013 SHALL drive col = ~(1 << column index), registered: index 0 -> 4'b1110, 3 -> 4'b0111.
REQ-014 SHALL sample synchronized row only on slot counter == SCAN_PERIOD-1 (settling margin for the 2-flop delay).
REQ-015 SHALL count pressed positions per frame (one frame = columns 0..3); the frame result is that key's code if exactly one position is low, otherwise NONE (zero keys or ghosting/multi-key).
REQ-016 SHALL map (row r, column c) to code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (c0..c3).
REQ-017 SHALL evaluate the frame result on the column-3 sample cycle; frame accumulators clear on the same edge.
REQ-018 SHALL implement FSM IDLE, PRESS_DB, HELD, REL_DB with a 4-bit frame-match counter and a 4-bit candidate code.
REQ-019 IDLE: key result K -> candidate=K, count=1, PRESS_DB (if DEBOUNCE==1, accept immediately, go HELD); NONE -> stay.
REQ-020 PRESS_DB: result == candidate -> count+1; count reaches DEBOUNCE -> accept, go HELD; different key -> restart with new candidate, count=1; NONE -> IDLE.
REQ-021 Accept: on the cycle after the deciding frame, key_code=candidate, gpio={gpio[11:0],candidate}, key_valid high exactly one cycle, key_down high.
REQ-022 HELD: result != held code (NONE or other key) -> count=1, REL_DB (DEBOUNCE==1: release immediately); result == held code -> stay.
REQ-023 REL_DB: result != held code -> count+1; reaching DEBOUNCE -> IDLE, key_down low; result == held code -> back to HELD, no new key_valid.
REQ-024 A second key pressed while held SHALL NOT generate key_valid until a full release (DEBOUNCE non-matching frames) followed by a new press debounce.
REQ-025 key_code and gpio SHALL hold their values between accepts and across releases.

Reset
REQ-026 On rst_n_i low, asynchronously: slot counter 0, column index 0, col=4'b1110, synchronizer and frame accumulators cleared, state IDLE, counters 0, key_code=0, key_valid=0, key_down=0, gpio=16'h0000.
REQ-027 Reset asserted mid-debounce or while HELD SHALL discard all progress; after release scanning restarts at column 0, slot 0, and no key_valid fires for a key held across reset until a fresh DEBOUNCE-frame acceptance.

Verification (SCAN_PERIOD=4, DEBOUNCE=2; frame = 16 cycles)
REQ-028 Reset then idle 64 cycles -> col sequences 1110,1101,1011,0111 every 4 cycles; key_valid never high; gpio=0000.
REQ-029 Hold row[1] low whenever col[2] low for 3 frames -> single key_valid pulse at end of frame 2, key_code=6, gpio=0006, key_down high.
REQ-030 Presses 1,A,F,0 each held 3 frames and released 3 frames -> four pulses, final gpio=1AF0, key_down low after each release.
REQ-031 Press 5, glitch release for 1 frame, continue -> one key_valid only; key_down stays high.
REQ-032 Press 1 and 2 simultaneously 4 frames -> no key_valid (NONE); pull rst_n_i low during PRESS_DB of key 9 -> outputs zero immediately, 9 accepted only 2 frames after reset release.
